// File: rtl/led_fader_if.sv
// led_fader_if: target pattern in, PWM drive and busy flag out, all on the fader clock.
// Latency: none; plain wires bundled for port connection.
// Backpressure: none; the fader accepts a new pattern every cycle.
interface led_fader_if;
  logic [4:0] led_in;   // target pattern from the LED rotator, bit i = LED(i+1)
  logic [4:0] led_out;  // registered PWM drive to the physical LEDs
  logic       busy;     // some channel has not yet reached its target

  // Upstream pattern source and LED consumer side
  modport master (
    output led_in,
    input  led_out,
    input  busy
  );

  // Fader side
  modport slave (
    input  led_in,
    output led_out,
    output busy
  );
endinterface

// File: rtl/led_fader.sv
// led_fader: five independent LED channels fading toward on/off targets, PWM-driven; gamma curve when LED_FADER_GAMMA_EN is defined.
// Latency: led_in -> led_q 1 cycle; level moves at the next step tick; led_out follows the new level 1 cycle after the tick.
// Backpressure: none; free-running, a new target pattern is sampled every cycle.
module led_fader #(
  parameter int PWM_BITS = 8,      // brightness / duty width
  parameter int STEP_DIV = 12000,  // clk cycles per brightness step tick, >= 2
  parameter int STEP     = 8       // brightness change per tick, 1..MAX
) (
  input  logic       clk,
  input  logic       rst,
  led_fader_if.slave bus
);

  localparam int NCH   = 5;
  localparam int DIV_W = $clog2(STEP_DIV);

  localparam logic [PWM_BITS-1:0] C_MAX      = '1;
  localparam logic [PWM_BITS:0]   C_MAX_X    = {1'b0, C_MAX};
  localparam logic [PWM_BITS:0]   C_STEP     = (PWM_BITS+1)'(STEP);
  localparam logic [DIV_W-1:0]    C_DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    C_DIV_ONE  = DIV_W'(1);

  // Registered state
  logic [NCH-1:0]      r_led_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [PWM_BITS-1:0] r_level [NCH];
  logic [NCH-1:0]      r_led_out;

  // Combinational helpers
  logic                w_step_tick;
  logic [PWM_BITS:0]   w_up     [NCH];
  logic [PWM_BITS:0]   w_dn     [NCH];
  logic [PWM_BITS-1:0] w_level_nxt [NCH];
  logic [PWM_BITS-1:0] w_duty   [NCH];
  logic                w_busy;

  assign w_step_tick = (r_div_cnt == C_DIV_LAST);

  // Capture the target pattern and run the PWM and step-tick counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_q   <= '0;
      r_pwm_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      r_led_q   <= bus.led_in;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_div_cnt <= w_step_tick ? '0 : (r_div_cnt + C_DIV_ONE);
    end
  end

  // Saturating next level per channel: one extra bit catches overflow past MAX
  // on the way up and the borrow below zero on the way down
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_up[i]        = {1'b0, r_level[i]} + C_STEP;
      w_dn[i]        = {1'b0, r_level[i]} - C_STEP;
      w_level_nxt[i] = r_level[i];
      if (r_led_q[i]) begin
        w_level_nxt[i] = (w_up[i] > C_MAX_X) ? C_MAX : w_up[i][PWM_BITS-1:0];
      end else begin
        w_level_nxt[i] = w_dn[i][PWM_BITS] ? '0 : w_dn[i][PWM_BITS-1:0];
      end
    end
  end

  // Move every channel one step toward its target on each step tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_level[i] <= '0;
      end
    end else if (w_step_tick) begin
      for (int i = 0; i < NCH; i++) begin
        r_level[i] <= w_level_nxt[i];
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq [NCH];

  // Square-law duty: full-width product of the level with itself, top half kept
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_sq[i]   = (2*PWM_BITS)'(r_level[i]) * (2*PWM_BITS)'(r_level[i]);
      w_duty[i] = PWM_BITS'(w_sq[i] >> PWM_BITS);
    end
  end
`else
  // Linear duty: brightness level drives the comparator directly
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_duty[i] = r_level[i];
    end
  end
`endif

  // PWM comparator; full level forces a steady on since the counter never exceeds MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_led_out[i] <= (r_level[i] == C_MAX) ? 1'b1 : (r_pwm_cnt < w_duty[i]);
      end
    end
  end

  // Busy while any channel level differs from its on/off target
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_level[i] != (r_led_q[i] ? C_MAX : '0)) begin
        w_busy = 1'b1;
      end
    end
  end

  assign bus.led_out = r_led_out;
  assign bus.busy    = w_busy;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: scoreboard bench for led_fader (PWM_BITS=4, STEP_DIV=4, STEP=4) plus a slow-tick instance for duty measurement.
// Latency: expected levels are queued when stimulus is applied and popped at each step tick.
// Backpressure: none; bench drives the pattern freely.
`timescale 1ns/1ps
module tb_led_fader;

  localparam int PB = 4;
  localparam int SD = 4;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_fader_if u_if ();
  led_fader_if u_if2 ();

  led_fader #(.PWM_BITS(PB), .STEP_DIV(SD), .STEP(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // Slow-tick instance: one tick of 8 lands on level 8 and holds it for 48 cycles
  led_fader #(.PWM_BITS(4), .STEP_DIV(48), .STEP(8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count since reset release; ticks land where it is a multiple of SD
  int tb_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (((tb_cyc % SD) != 0) && (n < 2*SD));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.led_in  = 5'b00001;
    u_if2.led_in = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (u_if.led_out !== 5'b00000) begin n_bad++; $display("FAIL reset_led_out got=%b want=%b", u_if.led_out, 5'b00000); end
    n_vec++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", u_if.busy); end
    n_vec++; if (dut.r_level[0] !== 4'd0) begin n_bad++; $display("FAIL reset_level0 got=%0d want=0", dut.r_level[0]); end
    rst = 1'b0;
    #1;
    n_vec++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL release_busy_pre got=%b want=0", u_if.busy); end
    @(posedge clk); #1;
    n_vec++; if (u_if.busy !== 1'b1) begin n_bad++; $display("FAIL release_busy_cyc2 got=%b want=1", u_if.busy); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (dut.r_level[0] !== 4'd0) begin n_bad++; $display("FAIL pre_first_tick_level got=%0d want=0", dut.r_level[0]); end
  endtask

  task automatic test_ramp_up();
    int tbl[5] = '{4, 8, 12, 15, 15};
    int e;
    int cnt;
    foreach (tbl[k]) exp_q.push_back(tbl[k]);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++; $display("FAIL ramp_up_queue_empty tick=%0d", k);
      end else begin
        e = exp_q.pop_front();
        n_vec++; if (int'(dut.r_level[0]) !== e) begin n_bad++; $display("FAIL ramp_up_level tick=%0d got=%0d want=%0d", k+1, dut.r_level[0], e); end
      end
      n_vec++; if (u_if.busy !== (k < 3)) begin n_bad++; $display("FAIL ramp_up_busy tick=%0d got=%b want=%b", k+1, u_if.busy, (k < 3)); end
    end
    cnt = 0;
    repeat (16) begin
      @(posedge clk); #1;
      cnt += int'(u_if.led_out[0]);
    end
    n_vec++; if (cnt !== 16) begin n_bad++; $display("FAIL full_on_high_cycles got=%0d want=16", cnt); end
    n_vec++; if (u_if.led_out[4:1] !== 4'b0000) begin n_bad++; $display("FAIL idle_channels got=%b want=0000", u_if.led_out[4:1]); end
  endtask

  task automatic test_ramp_down();
    int tbl[4] = '{11, 7, 3, 0};
    int e;
    int cnt;
    u_if.led_in = 5'b00000;
    foreach (tbl[k]) exp_q.push_back(tbl[k]);
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++; $display("FAIL ramp_down_queue_empty tick=%0d", k);
      end else begin
        e = exp_q.pop_front();
        n_vec++; if (int'(dut.r_level[0]) !== e) begin n_bad++; $display("FAIL ramp_down_level tick=%0d got=%0d want=%0d", k+1, dut.r_level[0], e); end
      end
      n_vec++; if (u_if.busy !== (k < 3)) begin n_bad++; $display("FAIL ramp_down_busy tick=%0d got=%b want=%b", k+1, u_if.busy, (k < 3)); end
    end
    cnt = 0;
    repeat (16) begin
      @(posedge clk); #1;
      cnt += int'(u_if.led_out[0]);
    end
    n_vec++; if (cnt !== 0) begin n_bad++; $display("FAIL full_off_high_cycles got=%0d want=0", cnt); end
    n_vec++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL full_off_busy got=%b want=0", u_if.busy); end
  endtask

  // Expected entries are level1*16 + level0
  task automatic test_back_to_back();
    int tbl[5] = '{4*16+0, 8*16+0, 4*16+4, 0*16+8, 4*16+4};
    int e;
    int obs;
    foreach (tbl[k]) exp_q.push_back(tbl[k]);
    u_if.led_in = 5'b00010;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) u_if.led_in = 5'b00001;
      if (k == 3) begin
        // land the pattern change inside the cycle that carries the step tick
        repeat (SD-1) @(posedge clk);
        #1;
        u_if.led_in = 5'b00010;
      end
      wait_tick();
      obs = int'(dut.r_level[1]) * 16 + int'(dut.r_level[0]);
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++; $display("FAIL b2b_queue_empty tick=%0d", k);
      end else begin
        e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_bad++; $display("FAIL b2b_levels tick=%0d got=l1:%0d,l0:%0d want=l1:%0d,l0:%0d", k+1, obs/16, obs%16, e/16, e%16); end
      end
    end
  endtask

  task automatic test_async_reset();
    u_if.led_in = 5'b00001;
    wait_tick();
    n_vec++; if (dut.r_level[0] !== 4'd8) begin n_bad++; $display("FAIL pre_rst_level0 got=%0d want=8", dut.r_level[0]); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (dut.r_level[0] !== 4'd0) begin n_bad++; $display("FAIL async_rst_level0 got=%0d want=0", dut.r_level[0]); end
    n_vec++; if (dut.r_level[1] !== 4'd0) begin n_bad++; $display("FAIL async_rst_level1 got=%0d want=0", dut.r_level[1]); end
    n_vec++; if (u_if.led_out !== 5'b00000) begin n_bad++; $display("FAIL async_rst_led_out got=%b want=00000", u_if.led_out); end
    n_vec++; if (u_if.busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy got=%b want=0", u_if.busy); end
  endtask

  task automatic test_pwm_duty();
    int cnt;
    int want;
`ifdef LED_FADER_GAMMA_EN
    want = 8;   // duty 4 of 16, over two periods
`else
    want = 16;  // duty 8 of 16, over two periods
`endif
    u_if.led_in  = 5'b00000;
    u_if2.led_in = 5'b00001;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    n_vec++; if (dut2.r_level[0] !== 4'd8) begin n_bad++; $display("FAIL duty_level got=%0d want=8", dut2.r_level[0]); end
    @(posedge clk); #1;
    cnt = 0;
    repeat (32) begin
      @(posedge clk); #1;
      cnt += int'(u_if2.led_out[0]);
    end
    n_vec++; if (cnt !== want) begin n_bad++; $display("FAIL duty_high_cycles got=%0d want=%0d", cnt, want); end
    n_vec++; if (dut2.r_level[0] !== 4'd8) begin n_bad++; $display("FAIL duty_level_held got=%0d want=8", dut2.r_level[0]); end
  endtask

  initial begin
    u_if.led_in  = 5'b00000;
    u_if2.led_in = 5'b00000;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_back_to_back();
    test_async_reset();
    test_pwm_duty();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout vectors=%0d", n_vec);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter PWM_BITS, default 8, brightness/duty width; MAX = 2^PWM_BITS-1.
REQ-002 Parameter STEP_DIV, default 12000, clk cycles per brightness step tick (>=2).
REQ-003 Parameter STEP, default 8, brightness change per step tick (1..MAX).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 led_in  input  5  target pattern from the upstream LED rotator, bit i = LED(i+1), same clk domain.
REQ-007 led_out  output  5  PWM drive to the physical LEDs, registered.
REQ-008 busy  output  1  high while any channel level differs from its target.

Function
REQ-009 led_in SHALL be captured into register led_q every cycle; all fade decisions use led_q only.
REQ-010 pwm_cnt (PWM_BITS wide) SHALL increment every cycle, wrapping MAX -> 0.
REQ-011 div_cnt SHALL count 0..STEP_DIV-1 and wrap; step_tick is high for exactly the one cycle where div_cnt == STEP_DIV-1.
REQ-012 Each channel SHALL hold level[i] (PWM_BITS wide), updated only on step_tick.
REQ-013 On step_tick with led_q[i]=1: level[i] = min(level[i]+STEP, MAX), computed without overflow (saturating).
REQ-014 On step_tick with led_q[i]=0: level[i] = max(level[i]-STEP, 0), no underflow (saturating).
REQ-015 Target of channel i SHALL be MAX if led_q[i]=1 else 0; busy = OR over i of (level[i] != target[i]), combinational from registers.
REQ-016 duty[i] SHALL be level[i] (linear) unless REQ-025 applies.
REQ-017 led_out[i] SHALL be registered as 1 when level[i]==MAX, else (pwm_cnt < duty[i]); level 0 gives constant 0, MAX gives constant 1.
REQ-018 Latency: led_in change reaches led_q after 1 cycle; level moves at the next step_tick; led_out reflects a new level 1 cycle after the tick.
REQ-019 If led_in changes in the same cycle as step_tick, that tick SHALL use the previous led_q value.
REQ-020 Channels SHALL be fully independent; multiple simultaneous active bits (non-one-hot input) are legal.
REQ-021 A channel at target SHALL hold its level on further ticks (no oscillation at 0 or MAX).

Reset
REQ-022 While rst=1: led_q, pwm_cnt, div_cnt, all level[i], led_out SHALL be 0, asynchronously, independent of clk.
REQ-023 After rst deasserts, first step_tick SHALL occur on the STEP_DIV-th rising edge; busy reads 0 until led_q captures a nonzero input.
REQ-024 rst mid-fade SHALL discard all levels; no partial state survives.

Configuration
REQ-025 Macro LED_FADER_GAMMA_EN defined: duty[i] = (level[i]*level[i]) >> PWM_BITS (full-width product, then shift), full-on rule of REQ-017 unchanged; undefined: duty[i] = level[i], no multiplier synthesized.

Verification (bench params PWM_BITS=4, STEP_DIV=4, STEP=4, MAX=15, macro undefined unless stated)
REQ-026 rst=1 with led_in=5'b00001 -> led_out=0, busy=0; release rst -> busy=1 from cycle 2, first tick on cycle 4.
REQ-027 Hold led_in=5'b00001 -> level[0] after ticks 1..5 = 4,8,12,15,15; after tick 4 led_out[0] constant 1, busy=0.
REQ-028 Then led_in=5'b00000 -> level[0] = 11,7,3,0; afterwards led_out[0] constant 0, busy=0.
REQ-029 level[0]=8 held -> led_out[0] high exactly 8 of every 16 cycles; with LED_FADER_GAMMA_EN, level 8 -> duty 4, high 4 of 16.
REQ-030 led_in 5'b00001 -> 5'b00010 in the cycle of a tick -> that tick raises level[0] and lowers level[1] (old led_q); next tick reverses.
REQ-031 Assert rst between clk edges at level[0]=8 -> led_out=0 and level[0]=0 before next clk edge.
